// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Latency: none, declarations only.
// Backpressure: not applicable.
package fetch_pkg;

  localparam int PC_INC       = 4;
  localparam int FETCH_ADDR_W = 6;
  localparam int FETCH_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] ins;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetched words with flush and async active-low clear.
// Latency: a pushed entry is visible at the head one cycle later; head read straight from storage.
// Backpressure: caller never pushes when full; flush beats push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  entry_t           push_dat,
  input  logic             pop,
  output entry_t           head_dat,
  output logic             head_vld,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !flush;
  assign do_pop   = pop && (count != '0) && !flush;
  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];

  // Storage is cleared too so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the fetch PC, keeps one imem request in flight, buffers words for decode.
// Latency: ack at edge N shows the word at the head in cycle N+1; redirect target no earlier than N+2.
// Backpressure: stops requesting when the prefetch FIFO would be full; decode pops via ins_valid/ins_ready.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int               ADDR_W   = FETCH_ADDR_W,
  parameter int               DATA_W   = FETCH_DATA_W,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_W-1:0]        imem_rdata,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     ins_valid,
  output logic [DATA_W-1:0]        ins,
  output logic [ADDR_W-1:0]        ins_pc,
  input  logic                     ins_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int                CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] INC   = ADDR_W'(PC_INC);

  typedef struct packed {
    logic [DATA_W-1:0] ins;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] start_pc;
  logic [CNT_W-1:0]  count_next;
  logic              can_req;
  logic              push;
  logic              pop;
  entry_t            push_dat;
  entry_t            head_dat;

  assign push       = (state == REQ) && imem_ack && !redirect_valid;
  assign pop        = ins_valid && ins_ready;
  assign count_next = redirect_valid ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign can_req    = (count_next < CNT_W'(DEPTH));
  // A redirect in the same cycle as a new issue sends that issue to the target.
  assign start_pc   = redirect_valid ? redirect_pc : fetch_pc;

  assign push_dat.ins = imem_rdata;
  assign push_dat.pc  = imem_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (can_req) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= start_pc;
            fetch_pc  <= start_pc + INC;
          end
        end
        REQ: begin
          if (imem_ack) begin
            if (can_req) begin
              imem_addr <= start_pc;
              fetch_pc  <= start_pc + INC;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end else if (redirect_valid) begin
            // The old request must still complete; its data is thrown away.
            state    <= DROP;
            fetch_pc <= redirect_pc;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state     <= REQ;
            imem_addr <= start_pc;
            fetch_pc  <= start_pc + INC;
          end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .flush    (redirect_valid),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .head_vld (ins_valid),
    .count    (fifo_count)
  );

  assign ins    = head_dat.ins;
  assign ins_pc = head_dat.pc;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end for the single-cycle MIPS core. It owns the fetch PC, issues requests to a variable-latency instruction memory, and buffers returned words with their PCs in a small prefetch FIFO. Decode consumes the words through a valid/ready handshake. A branch/jump redirect from the execute stage flushes the buffer and restarts fetch at the target.

## Interface
- `ADDR_W`, default 6: PC and memory byte-address width; addresses wrap modulo 2^ADDR_W.
- `DATA_W`, default 32: instruction width.
- `DEPTH`, default 4: prefetch FIFO entries; must be a power of two and ≥ 2.
- `RESET_PC`, default 0: first fetch address after reset.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-low; clears all state while low.
- `imem_req` out 1: request valid; registered.
- `imem_addr` out ADDR_W: request byte address; held stable while `imem_req` is high.
- `imem_ack` in 1: memory returns `imem_rdata` this cycle; valid only while `imem_req` is high.
- `imem_rdata` in DATA_W: fetched instruction.
- `redirect_valid` in 1: one-cycle pulse that flushes the buffer and restarts fetch.
- `redirect_pc` in ADDR_W: restart address.
- `ins_valid` out 1: FIFO head is valid.
- `ins` out DATA_W: head instruction.
- `ins_pc` out ADDR_W: PC of the head instruction.
- `ins_ready` in 1: decode accepts the head this cycle.
- `fifo_count` out $clog2(DEPTH)+1: current occupancy.

## Operation
- FSM has three states:
  - IDLE: no request outstanding.
  - REQ: request outstanding, response kept.
  - DROP: request outstanding, response is discarded.
- `fetch_pc` is the next address to request. It advances by 4 per accepted request and wraps naturally at ADDR_W bits.
- At most one request is outstanding. The request is held, with `imem_addr` unchanged, until the edge on which `imem_ack` is high. An ack in the same cycle `imem_req` first rises is legal (zero wait).
- IDLE → REQ when `count_next < DEPTH`. `imem_addr` is set to `fetch_pc`, then `fetch_pc` advances by 4.
- REQ with ack:
  - push `{imem_rdata, imem_addr}`;
  - stay in REQ with the next address if `count_next < DEPTH`, otherwise go to IDLE.
- Pop occurs when `ins_valid && ins_ready`. Push and pop in the same cycle leave the count unchanged. Pushing into a full FIFO cannot happen by construction; the bench asserts this.
- Redirect always wins over push and pop in the same cycle: the FIFO is flushed (count=0) and `fetch_pc` = `redirect_pc`.
  - IDLE or REQ-with-ack: the ack data is dropped; next state REQ with `imem_addr` = `redirect_pc`.
  - REQ without ack: go to DROP; `imem_req` stays high with the old address.
  - DROP: on ack, discard the data and go to REQ at `fetch_pc`. A redirect while in DROP only updates `fetch_pc`.
- Reset values: state IDLE, `fetch_pc` = RESET_PC, `imem_req` 0, `imem_addr` RESET_PC, FIFO empty, `ins_valid` 0, `ins` 0, `ins_pc` 0, `fifo_count` 0.
- Reset asserted mid-request abandons that request. The memory must tolerate `imem_req` dropping without an ack.

## Timing
- First `imem_req` is high one cycle after the first rising edge with `rst` high.
- Ack at edge N gives `ins_valid` high after edge N (visible in cycle N+1).
- With zero-wait memory and `ins_ready` held high, throughput is one instruction per cycle.
- Redirect at edge N:
  - `ins_valid` is low in cycle N+1;
  - if the machine was not in DROP, `imem_req` is high with `redirect_pc` in cycle N+1;
  - the first target instruction is visible no earlier than cycle N+2.
- `ins`/`ins_pc` come from the head register/array, with no combinational path from `imem_rdata`.
- `imem_req` and `imem_addr` are driven by flops only.

## Structure
- Package `fetch_pkg` holds:
  - `fetch_state_t` enum {IDLE, REQ, DROP};
  - `PC_INC` = 4;
  - a packed `fetch_entry_t` {ins, pc}.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t` with push, pop, flush, count and async active-low clear. Flush has priority over push and pop.
- The top level holds the FSM, `fetch_pc` and the request registers.

## Test plan
- Reset release, zero-wait memory, `ins_ready`=1, memory returns `0x1000_0000 + addr`:
  - addresses seen 0,4,8,…,60,0 (wrap);
  - `ins_pc` matches `ins` in every cycle;
  - one instruction per cycle.
- `ins_ready`=0 with zero-wait memory:
  - exactly 4 requests are acked, then `imem_req` drops and `fifo_count`=4;
  - raising `ins_ready` restarts fetch at address 16.
- Memory with a 3-cycle ack:
  - `imem_addr` is stable for all 3 cycles;
  - the word becomes valid the cycle after the ack.
- Redirect to 0x20 while a request is outstanding (ack 2 cycles later):
  - old data is discarded and the FIFO is empty;
  - the next request address is 0x20;
  - `ins_pc` of the first delivered instruction is 0x20.
- Redirect, ack and pop all in the same cycle:
  - `fifo_count`=0 and the acked word is never delivered;
  - the next request goes to `redirect_pc`.
- `rst` pulled low mid-request:
  - all outputs take their reset values asynchronously;
  - after release, fetch restarts at RESET_PC.
